// File: rtl/ifu_pkg.sv
// -----------------------------------------------------------------------------
// ifu_pkg
// Shared definitions for the instruction fetch unit and its helpers.
//   ifu_state_t : fetch sequencer states
//   RESP_OKAY   : the only bus read response treated as success
//   NOP_INST    : instruction substituted when a fetch fails (addi x0,x0,0)
//   RESET_PC    : first fetch address the core issues after reset
//   pc_aligned  : true when a fetch address is word aligned
// -----------------------------------------------------------------------------
package ifu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    DATA  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } ifu_state_t;

  localparam logic [1:0]  RESP_OKAY = 2'b00;
  localparam logic [31:0] NOP_INST  = 32'h00000013;
  localparam logic [31:0] RESET_PC  = 32'h80000000;

  // Instructions are 32-bit words, so the two low address bits must be zero.
  function automatic logic pc_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/ifu_perf.sv
// -----------------------------------------------------------------------------
// ifu_perf
// Free-running 32-bit performance counters for the fetch unit. Both wrap
// naturally at 2^32 and clear on reset.
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   fetch_ok        : one-cycle pulse when a fetch enters HOLD without error
//   stall           : high on each cycle the bus is waited on (ADDR/DATA with
//                     no handshake)
//   perf_fetch_cnt  : number of successful fetches delivered
//   perf_stall_cnt  : number of bus wait cycles observed
// -----------------------------------------------------------------------------
module ifu_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_ok,
  input  logic        stall,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
);

  // Both counters advance independently; they can never increment in the
  // same cycle for the same fetch, but nothing here relies on that.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= 32'd0;
      perf_stall_cnt <= 32'd0;
    end else begin
      if (fetch_ok) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (stall) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end

endmodule

// File: rtl/ifu.sv
// -----------------------------------------------------------------------------
// ifu
// Instruction fetch unit placed directly upstream of the single-cycle core.
// Takes a fetch PC from the core, reads the word over an AXI-lite style AR/R
// channel and hands the instruction, its PC and an error flag back to the
// core. Only one fetch is ever outstanding. A redirect (flush) abandons the
// current fetch; any bus transaction already started is completed and its
// data thrown away so the bus protocol is never violated.
//
// Optional build macro: IFU_PERF_CNT_EN adds perf_fetch_cnt / perf_stall_cnt
// outputs backed by the ifu_perf sub-module.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   pc_in/pc_valid      : fetch request from the core
//   pc_ready            : high while idle (combinational from state)
//   flush               : redirect, abandons the current fetch
//   araddr/arvalid      : bus read address channel (arready back)
//   rdata/rresp/rvalid  : bus read data channel (rready back)
//   inst/inst_pc        : fetched instruction and its address
//   inst_valid          : result valid, held until inst_ready or flush
//   fetch_err           : misaligned pc or non-OKAY bus response
// -----------------------------------------------------------------------------
module ifu #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_INST = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_valid,
  output logic              pc_ready,
  input  logic              flush,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic              fetch_err
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  import ifu_pkg::*;

  ifu_state_t state;

  // Remembers a flush that arrived while the address phase was still
  // waiting for arready; the read must still be drained once accepted.
  logic flush_pend;

  logic resp_err;

  assign resp_err = (rresp != RESP_OKAY);
  assign pc_ready = (state == IDLE);

  // Fetch sequencer. Every output except pc_ready is a register written here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      flush_pend <= 1'b0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      inst_valid <= 1'b0;
      fetch_err  <= 1'b0;
      inst       <= NOP_INST;
      inst_pc    <= '0;
      araddr     <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A pc offered together with a flush belongs to the old stream.
          if (pc_valid && !flush) begin
            inst_pc <= pc_in;
            if (pc_aligned(pc_in[1:0])) begin
              araddr  <= pc_in;
              arvalid <= 1'b1;
              state   <= ADDR;
            end else begin
              // Misaligned: answer locally without touching the bus.
              inst       <= NOP_INST;
              fetch_err  <= 1'b1;
              inst_valid <= 1'b1;
              state      <= HOLD;
            end
          end
        end

        ADDR: begin
          // arvalid may not be withdrawn, so a flush only redirects where
          // the sequencer goes once the address has been accepted.
          if (arready) begin
            arvalid    <= 1'b0;
            rready     <= 1'b1;
            flush_pend <= 1'b0;
            state      <= (flush || flush_pend) ? DRAIN : DATA;
          end else if (flush) begin
            flush_pend <= 1'b1;
          end
        end

        DATA: begin
          if (rvalid) begin
            rready <= 1'b0;
            if (flush) begin
              // Data arrived in the same cycle as the redirect: the beat is
              // already consumed, so drop it and skip DRAIN entirely.
              state <= IDLE;
            end else begin
              inst       <= resp_err ? NOP_INST : rdata;
              fetch_err  <= resp_err;
              inst_valid <= 1'b1;
              state      <= HOLD;
            end
          end else if (flush) begin
            state <= DRAIN;
          end
        end

        HOLD: begin
          if (flush || inst_ready) begin
            inst_valid <= 1'b0;
            state      <= IDLE;
          end
        end

        DRAIN: begin
          if (rvalid) begin
            rready <= 1'b0;
            state  <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic fetch_ok;
  logic stall;

  // A good fetch is counted on the cycle it moves from DATA into HOLD.
  assign fetch_ok = (state == DATA) && rvalid && !flush && !resp_err;
  assign stall    = ((state == ADDR) && !arready) ||
                    ((state == DATA) && !rvalid);

  ifu_perf u_perf (
    .clk            (clk),
    .rst            (rst),
    .fetch_ok       (fetch_ok),
    .stall          (stall),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_ifu.sv
// -----------------------------------------------------------------------------
// tb_ifu
// Self-checking bench for ifu. A table of fetch vectors drives a small bus
// and core responder; each fetch pushes its expected result onto a
// scoreboard queue that is popped when inst_valid appears. Hand-written
// sequences cover reset, flush and stall corner cases. Inputs change and
// outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_ifu;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        fetch_err;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int          ar_wait;
    int          r_wait;
    int          hold_wait;
    logic [31:0] exp_inst;
    logic        exp_err;
    int          exp_lat;
    logic        exp_bus;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];

  int tests;
  int failures;

  ifu dut (
    .clk        (clk),
    .rst        (rst),
    .pc_in      (pc_in),
    .pc_valid   (pc_valid),
    .pc_ready   (pc_ready),
    .flush      (flush),
    .araddr     (araddr),
    .arvalid    (arvalid),
    .arready    (arready),
    .rdata      (rdata),
    .rresp      (rresp),
    .rvalid     (rvalid),
    .rready     (rready),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .fetch_err  (fetch_err)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic idleInputs();
    arready    = 1'b0;
    rvalid     = 1'b0;
    rdata      = 32'hbad0bad0;
    rresp      = 2'b00;
    inst_ready = 1'b0;
    flush      = 1'b0;
    pc_valid   = 1'b0;
  endtask

  // One full fetch: handshake the pc, play bus and core with the vector's
  // wait counts, and compare the result against the scoreboard.
  task automatic applyStimulus(input vec_t v, input string tag);
    int   cyc;
    int   ar_cnt;
    int   r_cnt;
    int   h_cnt;
    int   lat;
    bit   saw_ar, ar_done, r_done, seen_iv, done;
    bit   ar_bad, hold_bad;
    exp_t e;
    exp_t held;
    ar_cnt = 0; r_cnt = 0; h_cnt = 0; lat = -1;
    saw_ar = 0; ar_done = 0; r_done = 0; seen_iv = 0; done = 0;
    ar_bad = 0; hold_bad = 0;
    held = '{32'h0, 32'h0, 1'b0};

    pc_in    = v.pc;
    pc_valid = 1'b1;
    sb.push_back('{v.exp_inst, v.pc, v.exp_err});
    tick();
    pc_valid = 1'b0;
    cyc = 1;

    while (!done && cyc < 60) begin
      arready    = 1'b0;
      rvalid     = 1'b0;
      rdata      = 32'hbad0bad0;
      inst_ready = 1'b0;
      if (ar_done && arvalid) ar_bad = 1;
      if (saw_ar && !ar_done && !arvalid) ar_bad = 1;
      if (arvalid && !ar_done) begin
        saw_ar = 1;
        if (araddr !== v.pc) ar_bad = 1;
        if (ar_cnt >= v.ar_wait) begin
          arready = 1'b1;
          ar_done = 1;
        end
        ar_cnt++;
      end else if (rready && ar_done && !r_done) begin
        if (r_cnt >= v.r_wait) begin
          rvalid = 1'b1;
          rdata  = v.rdata;
          rresp  = v.rresp;
          r_done = 1;
        end
        r_cnt++;
      end
      if (inst_valid) begin
        if (pc_ready) hold_bad = 1;
        if (!seen_iv) begin
          seen_iv = 1;
          lat     = cyc;
          held    = '{inst, inst_pc, fetch_err};
          if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput({tag, "_inst"}, inst, e.inst);
            checkOutput({tag, "_inst_pc"}, inst_pc, e.pc);
            checkOutput({tag, "_fetch_err"}, 32'(fetch_err), 32'(e.err));
          end else begin
            checkOutput({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
          end
        end else if (inst !== held.inst || inst_pc !== held.pc ||
                     fetch_err !== held.err) begin
          hold_bad = 1;
        end
        if (h_cnt >= v.hold_wait) begin
          inst_ready = 1'b1;
          done       = 1;
        end
        h_cnt++;
      end
      tick();
      cyc++;
    end
    idleInputs();

    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
    checkOutput({tag, "_bus_used"}, 32'(saw_ar), 32'(v.exp_bus));
    checkOutput({tag, "_ar_stable"}, 32'(ar_bad), 32'd0);
    checkOutput({tag, "_hold_stable"}, 32'(hold_bad), 32'd0);
    checkOutput({tag, "_back_idle"}, {30'd0, pc_ready, inst_valid}, 32'd2);
  endtask

  initial begin
    tests    = 0;
    failures = 0;
    pc_in    = 32'h0;
    rst      = 1'b1;
    idleInputs();

    //          pc            rdata         rresp  arw rw hw  exp_inst      err  lat bus
    vecs[0] = '{32'h80000000, 32'h00100093, 2'b00, 0, 0, 0, 32'h00100093, 1'b0, 3, 1'b1};
    vecs[1] = '{32'h80000004, 32'h00200113, 2'b00, 3, 0, 0, 32'h00200113, 1'b0, 6, 1'b1};
    vecs[2] = '{32'h80000002, 32'h11111111, 2'b00, 0, 0, 0, NOP,          1'b1, 1, 1'b0};
    vecs[3] = '{32'h80000008, 32'hdeadbeef, 2'b10, 0, 0, 0, NOP,          1'b1, 3, 1'b1};
    vecs[4] = '{32'h8000000c, 32'h00308193, 2'b00, 0, 0, 5, 32'h00308193, 1'b0, 3, 1'b1};
    vecs[5] = '{32'h80000010, 32'h00408213, 2'b00, 0, 2, 0, 32'h00408213, 1'b0, 5, 1'b1};
    vecs[6] = '{32'h00000001, 32'h22222222, 2'b00, 0, 0, 1, NOP,          1'b1, 1, 1'b0};
    vecs[7] = '{32'h80000014, 32'h12345678, 2'b11, 1, 0, 0, NOP,          1'b1, 4, 1'b1};

    // Reset values while rst is held.
    tick();
    tick();
    checkOutput("rst_ctrl", {27'd0, arvalid, rready, inst_valid, fetch_err, pc_ready},
                32'h1);
    checkOutput("rst_inst", inst, NOP);
    checkOutput("rst_inst_pc", inst_pc, 32'h0);
    checkOutput("rst_araddr", araddr, 32'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // pc offered together with flush in IDLE is ignored.
    pc_in    = 32'h80000060;
    pc_valid = 1'b1;
    flush    = 1'b1;
    tick();
    idleInputs();
    checkOutput("flush_idle_pc_ignored", {29'd0, arvalid, inst_valid, pc_ready}, 32'h1);
    tick();
    checkOutput("flush_idle_still_idle", {29'd0, arvalid, inst_valid, pc_ready}, 32'h1);

    // Flush in ADDR while arready is low: address held, read drained.
    pc_in    = 32'h80000020;
    pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    flush    = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flushA_arvalid_held", 32'(arvalid), 32'd1);
    checkOutput("flushA_araddr_held", araddr, 32'h80000020);
    tick();
    checkOutput("flushA_arvalid_held2", 32'(arvalid), 32'd1);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    checkOutput("flushA_drain", {28'd0, arvalid, rready, inst_valid, pc_ready}, 32'h4);
    rvalid = 1'b1;
    rdata  = 32'hcafef00d;
    tick();
    idleInputs();
    checkOutput("flushA_after", {28'd0, arvalid, rready, inst_valid, pc_ready}, 32'h1);

    // Flush in DATA: go to DRAIN, rready stays up, data dropped.
    pc_in    = 32'h80000040;
    pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    arready  = 1'b1;
    tick();
    arready = 1'b0;
    flush   = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flushD_drain", {29'd0, rready, inst_valid, pc_ready}, 32'h4);
    rvalid = 1'b1;
    rdata  = 32'h0badf00d;
    tick();
    idleInputs();
    checkOutput("flushD_after", {29'd0, rready, inst_valid, pc_ready}, 32'h1);

    // Flush in HOLD together with inst_ready.
    pc_in    = 32'h80000052;
    pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    checkOutput("flushH_hold", {30'd0, inst_valid, pc_ready}, 32'h2);
    flush      = 1'b1;
    inst_ready = 1'b1;
    tick();
    idleInputs();
    checkOutput("flushH_after", {30'd0, inst_valid, pc_ready}, 32'h1);

    // Reset asserted while waiting in DATA.
    pc_in    = 32'h80000030;
    pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    arready  = 1'b1;
    tick();
    arready = 1'b0;
    checkOutput("rstD_in_data", 32'(rready), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rstD_ctrl", {27'd0, arvalid, rready, inst_valid, fetch_err, pc_ready},
                32'h1);
    checkOutput("rstD_inst", inst, NOP);
    checkOutput("rstD_inst_pc", inst_pc, 32'h0);
    checkOutput("rstD_araddr", araddr, 32'h0);

    // A normal fetch still works after the mid-fetch reset.
    applyStimulus(vecs[0], "post_rst");

    checkOutput("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
